// File: rtl/wordcell_array_ctrl_pkg.sv
// Shared types and constants for the word-array controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package wordctrl_pkg;

    // Access sequence seen by the latch array.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wordctrl_state_e;

    localparam int   NUM_PORTS = 2;
    localparam logic OP_READ   = 1'b0;
    localparam logic OP_WRITE  = 1'b1;

endpackage

// File: rtl/wordcell_array_ctrl_if.sv
// Requester handshakes plus raw latch-array bus of the word-array controller.
// Latency: n/a (wiring only).
// Backpressure: reqN_ready qualifies reqN_valid; responses and array bus have none.
interface wordcell_array_ctrl_if #(
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8
) ();
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;

    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic                 mem_op;
    logic [NUM_WORDS-1:0] mem_sel;
    logic [DATA_W-1:0]    mem_in_bus;
    logic [DATA_W-1:0]    mem_out_bus;

    // Controller side.
    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output mem_op, mem_sel, mem_in_bus,
        input  mem_out_bus
    );

    // Requester / array side.
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  mem_op, mem_sel, mem_in_bus,
        output mem_out_bus
    );

endinterface

// File: rtl/wordcell_array_ctrl_arbiter.sv
// Two-way request arbiter; round-robin when WORDCTRL_RR_EN is defined, else port 0 fixed priority.
// Latency: combinational grant; round-robin pointer updates on the handshake edge.
// Backpressure: grant is only a selection, the caller qualifies it into ready.
module wordctrl_arbiter
    import wordctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] valid,
    input  logic                 handshake,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef WORDCTRL_RR_EN
    logic last_grant;   // 1 = port 1 won the most recent handshake

    // Remember the winner of each handshake; reset favours port 0 next.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (handshake) begin
            last_grant <= grant[1];
        end
    end

    // On contention the port that did not win last time goes first.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_arb_inputs;
    assign unused_arb_inputs = ^{clk, rst, handshake};

    // Port 0 always wins; port 1 only when port 0 is quiet.
    always_comb begin
        grant = valid;
        if (valid[0]) begin
            grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/wordcell_array_ctrl.sv
// Arbitrates two requesters onto a NAND-latch word array using setup/strobe/hold sequencing.
// Latency: response pulse 2+STROBE_CYCLES cycles after the accept cycle; next accept one cycle later.
// Backpressure: ready only in IDLE for the granted port; responses are not back-pressured.
// Build option WORDCTRL_RR_EN selects round-robin arbitration (default: port 0 fixed priority).
module wordcell_array_ctrl
    import wordctrl_pkg::*;
#(
    parameter int NUM_WORDS     = 8,
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    wordcell_array_ctrl_if.slave bus
);

    wordctrl_state_e state_q, state_d;

    logic [1:0]           cnt_q;
    logic                 cnt_last;
    logic                 op_q, op_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 port_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rsp_vld_q;
    logic                 mem_op_q;
    logic [NUM_WORDS-1:0] mem_sel_q;
    logic [DATA_W-1:0]    mem_in_q;

    logic [NUM_PORTS-1:0] valid_vec;
    logic [NUM_PORTS-1:0] grant;
    logic                 accept;
    logic                 handshake;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic                 in_range;
    logic [NUM_WORDS-1:0] sel_dec;
    logic                 rsp0_vld;
    logic                 rsp1_vld;

    assign valid_vec = {bus.req1_valid, bus.req0_valid};
    // Ready is withheld while reset is asserted so nothing is accepted into a state being cleared.
    assign accept    = (state_q == IDLE) && !rst;
    assign handshake = accept && (|valid_vec);

    assign bus.req0_ready = accept & grant[0];
    assign bus.req1_ready = accept & grant[1];

    wordctrl_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid_vec),
        .handshake (handshake),
        .grant     (grant)
    );

    // Out-of-range addresses run the full sequence with no word selected.
    assign in_range = (int'(addr_q) < NUM_WORDS);
    assign sel_dec  = in_range ? (NUM_WORDS'(1) << addr_q) : '0;
    assign cnt_last = (cnt_q == 2'(STROBE_CYCLES - 1));

    // Steer the granted port's request fields.
    always_comb begin
        req_write = bus.req0_write;
        req_addr  = bus.req0_addr;
        req_wdata = bus.req0_wdata;
        if (grant[1]) begin
            req_write = bus.req1_write;
            req_addr  = bus.req1_addr;
            req_wdata = bus.req1_wdata;
        end
    end

    // Sequence next state and capture of the accepted request.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = SETUP;
                    op_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            SETUP:   state_d = STROBE;
            STROBE:  if (cnt_last) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request registers and strobe counter; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            port_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (handshake) begin
                port_q <= grant[1];
            end
            cnt_q <= (state_q == STROBE && !cnt_last) ? cnt_q + 2'd1 : 2'd0;
        end
    end

    // Array drive is registered from the next state, so select only ever rises a cycle after op/data settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_op_q  <= OP_READ;
            mem_in_q  <= '0;
            mem_sel_q <= '0;
        end else begin
            mem_op_q  <= (state_d != IDLE) ? op_d : OP_READ;
            mem_in_q  <= (state_d != IDLE) ? wdata_d : '0;
            mem_sel_q <= (state_d == STROBE) ? sel_dec : '0;
        end
    end

    // Read data is sampled on the edge closing the last strobe cycle; the pulse lands in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            rsp_vld_q <= (state_d == HOLD);
            if (state_q == STROBE && cnt_last) begin
                rdata_q <= (op_q == OP_READ && in_range) ? bus.mem_out_bus : '0;
            end
        end
    end

    assign rsp0_vld = rsp_vld_q && !port_q;
    assign rsp1_vld = rsp_vld_q && port_q;

    assign bus.rsp0_valid = rsp0_vld;
    assign bus.rsp1_valid = rsp1_vld;
    assign bus.rsp0_rdata = rsp0_vld ? rdata_q : '0;
    assign bus.rsp1_rdata = rsp1_vld ? rdata_q : '0;
    assign bus.mem_op     = mem_op_q;
    assign bus.mem_sel    = mem_sel_q;
    assign bus.mem_in_bus = mem_in_q;

endmodule

// File: tb/tb_wordcell_array_ctrl.sv
// Bench for wordcell_array_ctrl: dut0 = 8 words / 1 strobe cycle, dut1 = 6 words / 3 strobe cycles.
// A transaction-level timeline model checks every output of both DUTs each cycle.
// Directed scenarios add literal expectations on latency, select shape, data and grant order.
module tb_wordcell_array_ctrl;

    localparam int NW0 = 8;
    localparam int S0  = 1;
    localparam int NW1 = 6;
    localparam int S1  = 3;
    localparam int AW  = 3;
    localparam int DW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    logic [1:0] rstv;
    assign rstv = {rst1, rst0};

    wordcell_array_ctrl_if #(.NUM_WORDS(NW0), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
    wordcell_array_ctrl_if #(.NUM_WORDS(NW1), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

    wordcell_array_ctrl #(.NUM_WORDS(NW0), .ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );
    wordcell_array_ctrl #(.NUM_WORDS(NW1), .ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    // Stimulus variables, indexed [dut][port].
    logic [1:0][1:0]         v, w;
    logic [1:0][1:0][AW-1:0] a;
    logic [1:0][1:0][DW-1:0] wdt;

    assign bus0.req0_valid = v[0][0];  assign bus0.req0_write = w[0][0];
    assign bus0.req0_addr  = a[0][0];  assign bus0.req0_wdata = wdt[0][0];
    assign bus0.req1_valid = v[0][1];  assign bus0.req1_write = w[0][1];
    assign bus0.req1_addr  = a[0][1];  assign bus0.req1_wdata = wdt[0][1];
    assign bus1.req0_valid = v[1][0];  assign bus1.req0_write = w[1][0];
    assign bus1.req0_addr  = a[1][0];  assign bus1.req0_wdata = wdt[1][0];
    assign bus1.req1_valid = v[1][1];  assign bus1.req1_write = w[1][1];
    assign bus1.req1_addr  = a[1][1];  assign bus1.req1_wdata = wdt[1][1];

    // Observed outputs, indexed [dut] (and [port]).
    logic [1:0][1:0]         o_rdy, o_rv;
    logic [1:0][1:0][DW-1:0] o_rd;
    logic [1:0]              o_op;
    logic [1:0][7:0]         o_sel;
    logic [1:0][DW-1:0]      o_in;

    assign o_rdy[0] = {bus0.req1_ready, bus0.req0_ready};
    assign o_rdy[1] = {bus1.req1_ready, bus1.req0_ready};
    assign o_rv[0]  = {bus0.rsp1_valid, bus0.rsp0_valid};
    assign o_rv[1]  = {bus1.rsp1_valid, bus1.rsp0_valid};
    assign o_rd[0]  = {bus0.rsp1_rdata, bus0.rsp0_rdata};
    assign o_rd[1]  = {bus1.rsp1_rdata, bus1.rsp0_rdata};
    assign o_op     = {bus1.mem_op, bus0.mem_op};
    assign o_sel[0] = bus0.mem_sel;
    assign o_sel[1] = {2'b00, bus1.mem_sel};
    assign o_in[0]  = bus0.mem_in_bus;
    assign o_in[1]  = bus1.mem_in_bus;

    // Behavioural latch arrays: a word is transparent while selected in write mode.
    logic [DW-1:0] cell0 [NW0] = '{default: '0};
    logic [DW-1:0] cell1 [NW1] = '{default: '0};

    always @* begin
        for (int i = 0; i < NW0; i++)
            if (bus0.mem_sel[i] && bus0.mem_op) cell0[i] = bus0.mem_in_bus;
    end
    always @* begin
        for (int i = 0; i < NW1; i++)
            if (bus1.mem_sel[i] && bus1.mem_op) cell1[i] = bus1.mem_in_bus;
    end
    always_comb begin
        bus0.mem_out_bus = '0;
        for (int i = 0; i < NW0; i++)
            if (bus0.mem_sel[i]) bus0.mem_out_bus = bus0.mem_out_bus | cell0[i];
    end
    always_comb begin
        bus1.mem_out_bus = '0;
        for (int i = 0; i < NW1; i++)
            if (bus1.mem_sel[i]) bus1.mem_out_bus = bus1.mem_out_bus | cell1[i];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%0h, want 0x%0h", d, nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // age = cycles since the accepting edge (0 = idle): 1 setup, 2..1+S strobe, 2+S hold.
    int            nw   [2] = '{NW0, NW1};
    int            sc   [2] = '{S0, S1};
    int            age  [2] = '{0, 0};
    logic          en   [2] = '{1'b0, 1'b0};
    logic          m_port [2];
    logic          m_wr   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata[2];
    logic [DW-1:0] m_mem  [2][8] = '{default: '0};
`ifdef WORDCTRL_RR_EN
    logic          m_last [2] = '{1'b1, 1'b1};
`endif

    function automatic logic [1:0] pick(input int d);
        logic [1:0] vv;
        vv = v[d];
`ifdef WORDCTRL_RR_EN
        if (vv == 2'b11) return m_last[d] ? 2'b01 : 2'b10;
`else
        if (vv == 2'b11) return 2'b01;
`endif
        return vv;
    endfunction

    initial begin
        logic [1:0]    g, e_rv;
        logic [7:0]    e_sel;
        logic [DW-1:0] e_rd;
        logic          strobe, hold, inr;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                g      = pick(d);
                strobe = (age[d] >= 2) && (age[d] <= 1 + sc[d]);
                hold   = (age[d] == 2 + sc[d]);
                inr    = (int'(m_addr[d]) < nw[d]);
                e_sel  = (strobe && inr) ? (8'd1 << m_addr[d]) : 8'd0;
                e_rv   = hold ? (m_port[d] ? 2'b10 : 2'b01) : 2'b00;
                e_rd   = (hold && !m_wr[d] && inr) ? m_mem[d][m_addr[d]] : '0;
                if (en[d]) begin
                    chk(d, "req_ready", o_rdy[d], (age[d] == 0 && !rstv[d]) ? g : 2'b00);
                    chk(d, "rsp_valid", o_rv[d], e_rv);
                    chk(d, "rsp0_rdata", o_rd[d][0], e_rv[0] ? e_rd : '0);
                    chk(d, "rsp1_rdata", o_rd[d][1], e_rv[1] ? e_rd : '0);
                    chk(d, "mem_op", o_op[d], (age[d] != 0) ? m_wr[d] : 1'b0);
                    chk(d, "mem_sel", o_sel[d], e_sel);
                    chk(d, "mem_in_bus", o_in[d], (age[d] != 0) ? m_wdata[d] : '0);
                end
                if (rstv[d]) begin
                    age[d] = 0;
                    en[d]  = 1'b1;
`ifdef WORDCTRL_RR_EN
                    m_last[d] = 1'b1;
`endif
                end else if (age[d] == 0) begin
                    if (g != 2'b00) begin
                        age[d]     = 1;
                        m_port[d]  = g[1];
                        m_wr[d]    = w[d][g[1]];
                        m_addr[d]  = a[d][g[1]];
                        m_wdata[d] = wdt[d][g[1]];
`ifdef WORDCTRL_RR_EN
                        m_last[d]  = g[1];
`endif
                    end
                end else if (hold) begin
                    if (m_wr[d] && inr) m_mem[d][m_addr[d]] = m_wdata[d];
                    age[d] = 0;
                end else begin
                    age[d] = age[d] + 1;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    int            sel_cnt;
    logic [7:0]    sel_or;
    logic [DW-1:0] in_pre, in_hold;

    // Issue one request, wait for accept, then follow it to its response pulse.
    task automatic run_txn(input int d, input int p, input logic wr, input logic [AW-1:0] ad,
                           input logic [DW-1:0] dat, output int lat, output logic [DW-1:0] rd);
        int k;
        logic [DW-1:0] prev_in;
        @(posedge clk); #1;
        v[d][p] = 1'b1; w[d][p] = wr; a[d][p] = ad; wdt[d][p] = dat;
        lat = -1; rd = '0; sel_cnt = 0; sel_or = '0; in_pre = '0; in_hold = '0; prev_in = '0;
        k = 0;
        @(negedge clk);
        while (!o_rdy[d][p] && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        v[d][p] = 1'b0;
        if (k >= 50) return;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_sel[d] != 8'd0) begin
                if (sel_cnt == 0) in_pre = prev_in;
                sel_cnt++;
                sel_or = sel_or | o_sel[d];
            end
            prev_in = o_in[d];
            if (o_rv[d][p]) begin
                lat = c;
                in_hold = o_in[d];
                rd = o_rd[d][p];
                break;
            end
        end
    endtask

    initial begin
        int            lat, k, n, rv_seen;
        logic [DW-1:0] rd;
        logic [3:0]    seq;

        v = '0; w = '0; a = '0; wdt = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(d, "reset_ready", o_rdy[d], 0);
            chk(d, "reset_rsp_valid", o_rv[d], 0);
            chk(d, "reset_mem_sel", o_sel[d], 0);
            chk(d, "reset_mem_op", o_op[d], 0);
            chk(d, "reset_mem_in", o_in[d], 0);
        end
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;

        // Write 0x55 to word 3, then read it back on port 0.
        run_txn(0, 0, 1'b1, 3'd3, 8'h55, lat, rd);
        chk(0, "wr_latency", lat, 3);
        chk(0, "wr_sel_shape", sel_or, 8'b0000_1000);
        chk(0, "wr_sel_cycles", sel_cnt, 1);
        chk(0, "wr_rdata_zero", rd, 8'h00);
        run_txn(0, 0, 1'b0, 3'd3, 8'h00, lat, rd);
        chk(0, "rd_latency", lat, 3);
        chk(0, "rd_data", rd, 8'h55);
        chk(0, "rd_sel_shape", sel_or, 8'b0000_1000);

        // Both ports contend continuously after a fresh reset.
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        w[0] = 2'b11; a[0][0] = 3'd1; a[0][1] = 3'd5; wdt[0][0] = 8'h11; wdt[0][1] = 8'h22;
        v[0] = 2'b11;
        seq = 4'hF; n = 0; k = 0;
        while (n < 4 && k < 60) begin
            @(negedge clk);
            k++;
            if (o_rdy[0][0]) begin seq[n] = 1'b0; n++; end
            else if (o_rdy[0][1]) begin seq[n] = 1'b1; n++; end
        end
        @(posedge clk); #1;
        v[0] = 2'b00;
`ifdef WORDCTRL_RR_EN
        chk(0, "grant_order", seq, 4'b1010);
`else
        chk(0, "grant_order", seq, 4'b0000);
`endif
        repeat (8) @(posedge clk);

        // Reset lands during the strobe of a port-1 write to word 6.
        @(posedge clk); #1;
        v[0][1] = 1'b1; w[0][1] = 1'b1; a[0][1] = 3'd6; wdt[0][1] = 8'h77;
        k = 0;
        @(negedge clk);
        while (!o_rdy[0][1] && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        v[0][1] = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(negedge clk);
        chk(0, "pre_reset_strobe_sel", o_sel[0], 8'b0100_0000);
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        chk(0, "post_reset_sel", o_sel[0], 0);
        chk(0, "post_reset_op", o_op[0], 0);
        chk(0, "post_reset_in", o_in[0], 0);
        chk(0, "post_reset_rdata", o_rd[0], 0);
        rv_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_rv[0] != 2'b00) rv_seen++;
            @(negedge clk);
        end
        chk(0, "dropped_rsp_count", rv_seen, 0);
        run_txn(0, 0, 1'b1, 3'd2, 8'h3C, lat, rd);
        chk(0, "after_reset_wr_latency", lat, 3);
        run_txn(0, 1, 1'b0, 3'd2, 8'h00, lat, rd);
        chk(0, "after_reset_rd_data", rd, 8'h3C);

        // Three-cycle strobe: data leads and trails the select.
        run_txn(1, 0, 1'b1, 3'd0, 8'hCC, lat, rd);
        chk(1, "s3_latency", lat, 5);
        chk(1, "s3_sel_cycles", sel_cnt, 3);
        chk(1, "s3_sel_shape", sel_or, 8'h01);
        chk(1, "s3_data_before_sel", in_pre, 8'hCC);
        chk(1, "s3_data_in_hold", in_hold, 8'hCC);

        // Out-of-range word 7 on a 6-word array.
        run_txn(1, 0, 1'b1, 3'd7, 8'hFF, lat, rd);
        chk(1, "oor_wr_sel", sel_or, 8'h00);
        chk(1, "oor_wr_latency", lat, 5);
        run_txn(1, 0, 1'b0, 3'd7, 8'h00, lat, rd);
        chk(1, "oor_rd_sel", sel_or, 8'h00);
        chk(1, "oor_rd_data", rd, 8'h00);
        chk(1, "oor_rd_latency", lat, 5);
        run_txn(1, 1, 1'b0, 3'd0, 8'h00, lat, rd);
        chk(1, "port1_rd_data", rd, 8'hCC);
        chk(1, "port1_rd_latency", lat, 5);

        repeat (6) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wordcell_array_ctrl.md
# wordcell_array_ctrl

Sequencing controller and two-port arbiter for a `NUM_WORDS`-deep array of NAND-latch `Wordcell` words. It accepts read and write requests from two requesters and grants one at a time. For each access it drives the array's `op`, one-hot word select and input bus in a setup / strobe / hold sequence, so the level-sensitive latches never see select and data changing together. It sits between the bus-side requesters and the raw latch array.

## Interface
Parameters:
- `NUM_WORDS`, 8: number of words in the array.
- `ADDR_W`, 3: request address width; must satisfy `2**ADDR_W >= NUM_WORDS`.
- `DATA_W`, 8: word width.
- `STROBE_CYCLES`, 1: cycles the select line is held high; legal range 1–4.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_write` / `req1_write` in 1: 1 = write, 0 = read.
- `req0_addr` / `req1_addr` in `ADDR_W`: word address.
- `req0_wdata` / `req1_wdata` in `DATA_W`: write data.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle when valid is also high.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle completion pulse. Not back-pressured.
- `rsp0_rdata` / `rsp1_rdata` out `DATA_W`: read data, valid with the pulse. 0 for writes.
- `mem_op` out 1: `Wordcell` `op` (1 = write, 0 = read).
- `mem_sel` out `NUM_WORDS`: one-hot word select. All-zero when idle.
- `mem_in_bus` out `DATA_W`: data to the array.
- `mem_out_bus` in `DATA_W`: OR of all word outputs. An unselected word contributes 0.

## Operation
- The FSM has four states: `IDLE`, `SETUP`, `STROBE`, `HOLD`.
- **IDLE**
  - The arbiter picks a grant from the valid requests.
  - `reqN_ready` is high only for the granted port, and only in `IDLE`.
  - On a handshake, the controller registers op, addr and wdata, then moves to `SETUP`.
- **SETUP** (1 cycle): `mem_op` and `mem_in_bus` are driven from the registered values; `mem_sel` = 0.
- **STROBE** (`STROBE_CYCLES` cycles)
  - `mem_sel[addr]` = 1 when `addr < NUM_WORDS`, otherwise all-zero.
  - `mem_op` and `mem_in_bus` stay stable.
  - On a read, `mem_out_bus` is captured at the rising edge that ends the last `STROBE` cycle.
- **HOLD** (1 cycle)
  - `mem_sel` = 0, while `mem_op` and `mem_in_bus` stay unchanged.
  - `rspN_valid` = 1 for the owning port, with `rspN_rdata` = captured data on a read and 0 on a write.
  - Next state is `IDLE`.
- **Out-of-range address** (`addr >= NUM_WORDS`): the full sequence runs with no select asserted. A read returns 0.
- **Arbitration:** one request is granted at a time. A port may drop `valid` before `ready` with no effect.
- **Unused outputs:** `mem_in_bus` is 0 and `mem_op` is 0 in `IDLE`.

## Timing
- **Handshake:** at cycle 0 (in `IDLE`), a handshake occurs.
- **Sequence:** cycle 1 is `SETUP`; cycles 2 .. 1+S are `STROBE` (S = `STROBE_CYCLES`); cycle 2+S is `HOLD` with `rsp_valid`.
- **Next accept:** earliest in cycle 3+S. With S=1, throughput is one access per 4 cycles.
- **Reset:**
  - Asserting `rst` at any edge forces `IDLE`; every output (`mem_*`, `req*_ready`, `rsp*_valid`, `rsp*_rdata`) goes to 0 on the next edge.
  - An in-flight transaction is dropped with no response, including a partial write.
  - The round-robin pointer resets to favour port 0.
- **Select stability:** `mem_sel` never goes high in the same cycle that `mem_op` or `mem_in_bus` changes.

## Configuration
- `WORDCTRL_RR_EN` defined:
  - Round-robin arbitration. On simultaneous valid requests, the port not granted last wins.
  - The pointer updates only on a handshake.
- `WORDCTRL_RR_EN` undefined:
  - Fixed priority, with port 0 always winning.
  - There is no pointer register.

## Structure
- **`wordctrl_pkg`:**
  - FSM state enum `wordctrl_state_e`.
  - `NUM_PORTS = 2`.
  - `OP_READ` / `OP_WRITE` localparams.
- **`wordctrl_arbiter`:** a natural sub-module. It is the two-way grant logic with an optional RR pointer (macro-guarded), taking `clk`, `rst`, the valid vector and the handshake pulse.
- **Top:** FSM, strobe counter, request and capture registers, and response routing.

## Test plan
- **Write then read:** reset, then port 0 writes 0x55 to addr 3, then reads addr 3.
  - `mem_sel` = 8'b00001000 only in `STROBE`.
  - `rsp0_valid` appears 3 cycles after each accept.
  - Read returns `rsp0_rdata` = 0x55.
- **Contention:** both ports are valid in the same cycle, each writing different addresses, and both keep requesting.
  - With `WORDCTRL_RR_EN`, grants alternate 0, 1, 0, 1.
  - Without it, port 0 is granted repeatedly and port 1 is starved.
- **Setup/hold ordering:** write 0xCC to addr 0 with `STROBE_CYCLES` = 3.
  - `mem_in_bus` = 0xCC one cycle before `mem_sel[0]` rises.
  - `mem_sel[0]` is high for exactly 3 cycles.
  - Data is still 0xCC in `HOLD`.
- **Out-of-range:** with `NUM_WORDS` = 6, read addr 7.
  - `mem_sel` stays 0 throughout.
  - `rsp_valid` arrives with rdata = 0.
- **Reset mid-operation:** assert `rst` during `STROBE` of a write.
  - Next cycle, all outputs are 0 and there is no `rsp_valid`.
  - A following request is accepted normally.
